// File: rtl/cc_fstall_issue_if.sv
// cc_fstall_issue_if
//   Bundles the producer-side push handshake, the consumer-side stall and
//   issue signals, and the status outputs of cc_fstall_issue.
//   master : the environment (producer / consumer / flush source)
//   slave  : the issue stage itself
//   Signals:
//     except      flush request (env -> stage)
//     fstall      consumer stall (env -> stage)
//     in_valid    producer offers in_data (env -> stage)
//     in_data     producer word (env -> stage)
//     in_ready    stage can accept a word (stage -> env)
//     en          write_data carries a valid word (stage -> env)
//     write_data  issued word, zero when en=0 (stage -> env)
//     count       FIFO occupancy, excluding the output register (stage -> env)
//     stall_long  stall with a valid word has lasted too long (stage -> env)
interface cc_fstall_issue_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             except;
    logic             fstall;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             en;
    logic [WIDTH-1:0] write_data;
    logic [CW-1:0]    count;
    logic             stall_long;

    modport master (
        output except, fstall, in_valid, in_data,
        input  in_ready, en, write_data, count, stall_long
    );

    modport slave (
        input  except, fstall, in_valid, in_data,
        output in_ready, en, write_data, count, stall_long
    );
endinterface

// File: rtl/cc_fstall_issue.sv
// cc_fstall_issue
//   Stall-tolerant issue stage. Incoming words are buffered in a DEPTH-entry
//   FIFO and issued one per cycle onto a registered en/write_data pair. While
//   the consumer holds fstall the output register and FIFO head are frozen,
//   but pushes continue. except flushes everything; a saturating counter
//   flags stalls that persist for STALL_MAX cycles with a valid word shown.
//   Ports:
//     clk  clock, all state on the rising edge
//     rst  synchronous active-high reset (overrides except)
//     bus  cc_fstall_issue_if.slave: except, fstall, in_valid, in_data in;
//          in_ready, en, write_data, count, stall_long out
module cc_fstall_issue #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int STALL_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    cc_fstall_issue_if.slave     bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STALL_MAX + 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
    localparam logic [SW-1:0] STALL_LIMIT = SW'(STALL_MAX);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             en_reg, en_next;
    logic [WIDTH-1:0] wd_reg, wd_next;
    logic [SW-1:0]    stall_cnt_reg, stall_cnt_next;
    logic             stall_long_reg, stall_long_next;

    logic in_ready_int;
    logic push;
    logic pop;

    // in_ready looks only at registered occupancy and except: a pop on the
    // same edge does not open a slot (no full pass-through).
    assign in_ready_int = (count_reg != FULL_COUNT) && !bus.except;
    assign push         = bus.in_valid && in_ready_int;
    assign pop          = !bus.fstall && (count_reg != '0) && !bus.except;

    // Storage carries no reset; stale contents are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.in_data;
        end
    end

    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg;
        en_next         = en_reg;
        wd_next         = wd_reg;
        stall_cnt_next  = '0;
        stall_long_next = 1'b0;

        if (bus.except) begin
            // Flush wins over fstall and any concurrent push.
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            en_next     = 1'b0;
            wd_next     = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end

            // Output register only moves when the consumer is not stalling.
            if (!bus.fstall) begin
                if (pop) begin
                    wd_next     = mem[rd_ptr_reg];
                    en_next     = 1'b1;
                    rd_ptr_next = rd_ptr_reg + 1'b1;
                end else begin
                    wd_next = '0;
                    en_next = 1'b0;
                end
            end

            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase

            // Count consecutive edges stalled with a valid word, saturating.
            if (bus.fstall && en_reg) begin
                if (stall_cnt_reg != STALL_LIMIT) begin
                    stall_cnt_next = stall_cnt_reg + 1'b1;
                end else begin
                    stall_cnt_next = stall_cnt_reg;
                end
                stall_long_next = (stall_cnt_next == STALL_LIMIT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            en_reg         <= 1'b0;
            wd_reg         <= '0;
            stall_cnt_reg  <= '0;
            stall_long_reg <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            en_reg         <= en_next;
            wd_reg         <= wd_next;
            stall_cnt_reg  <= stall_cnt_next;
            stall_long_reg <= stall_long_next;
        end
    end

    assign bus.in_ready   = in_ready_int;
    assign bus.en         = en_reg;
    assign bus.write_data = wd_reg;
    assign bus.count      = count_reg;
    assign bus.stall_long = stall_long_reg;
endmodule
